fuzzy_sample_loader: RTL and testbench
======================================

# fuzzy_sample_loader

Input front end for the fuzzy wavelet core. It captures parallel samples presented on user IO pads, qualified by an asynchronous external strobe. Each sample passes through a two-flop synchronizer into a small first-word-fall-through FIFO. The FIFO drains to the wavelet core over a valid/ready handshake. The block sits between the io_in pad bits and the core's sample input inside wrapped_fuzzy_wavelet, and reports back-pressure and overflow on pad outputs.

## Interface
- DATA_W, 8: sample width in bits.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.

- wb_clk_i  input  1  sole clock; all logic is on its rising edge.
- wb_rst_i  input  1  reset; synchronous, active-high.
- pad_data  input  DATA_W  sample bits from io_in; asynchronous to wb_clk_i.
- pad_strobe  input  1  from io_in; asynchronous. A rising edge marks pad_data valid.
- pad_busy  output  1  FIFO full, registered; drives io_out.
- pad_overflow  output  1  sticky flag; set when a sample was dropped.
- smp_data  output  DATA_W  head-of-FIFO sample to the wavelet core.
- smp_valid  output  1  FIFO not empty.
- smp_ready  input  1  core accepts smp_data this cycle.
- fifo_count  output  CNT_W  current occupancy, 0..DEPTH.

## Operation
- **Synchronizer**
  - pad_strobe passes through stages s1→s2; a third flop s3 holds the previous s2.
  - pad_data passes through two matching stages d1→d2, so d2 is aligned with s2.
  - External requirement: pad_data is stable from ≥3 wb_clk_i cycles before the pad_strobe rising edge until its falling edge.
- **Capture**
  - cap = s2 & ~s3.
  - On cap, d2 is offered to the FIFO write port. Exactly one write per strobe rising edge.
  - A strobe held high produces no further captures.
- **FIFO**
  - Circular buffer with read and write pointers of log2(DEPTH) bits each; both wrap from DEPTH-1 to 0.
  - The count register is separate from the pointers.
  - push = cap & (count<DEPTH | pop). pop = smp_valid & smp_ready.
  - Push and pop in the same cycle: both occur and count is unchanged. This holds when full: a pop frees the slot for the push in the same cycle.
  - Push with count==0 and no pop: the entry appears at smp_data on the next cycle (first-word fall-through).
  - Pop while empty: impossible, since smp_valid=0. smp_ready is ignored when smp_valid=0.
- **Overflow**
  - Condition: cap & count==DEPTH & ~pop.
  - The sample is discarded and pad_overflow is set to 1.
  - pad_overflow clears only on reset.
- **Outputs**
  - smp_valid = (count≠0).
  - smp_data = mem[rd_ptr]. Its value is don't-care while smp_valid=0.
  - pad_busy = (count==DEPTH), as a registered value.
  - fifo_count = count.
- **Reset (wb_rst_i=1 at a clock edge)**
  - s1, s2, s3, d1, d2, pointers, count and pad_overflow all go to 0.
  - Memory contents are not reset.
  - Outputs during and after reset: smp_valid=0, pad_busy=0, pad_overflow=0, fifo_count=0.
  - Reset mid-operation discards all queued samples and any in-flight strobe.
  - A strobe held high across reset release is treated as a new rising edge: exactly one capture, of d2, 3 cycles after release.

## Timing
- Edge E0 first samples pad_strobe=1. s1=1 after E0 and s2=1 after E1. cap is high in the cycle after E1 and the write occurs at E2.
  - With an empty FIFO, smp_valid=1 and smp_data=sample after E2: 3-edge latency from pad to core.
- Pop at edge E: the next entry, or smp_valid=0, is visible after E. Back-to-back pops every cycle are supported.
- pad_busy and fifo_count update on the same edge as the push/pop that changes count.
- Sustained throughput is one sample per strobe. The strobe's minimum high and low times are each 2 wb_clk_i cycles.

## Test plan
- Single sample, smp_ready=1:
  - Stimulus: pad_data=0xA5; pad_strobe rises for 4 cycles.
  - Required: smp_valid pulses for 1 cycle with smp_data=0xA5, exactly 3 edges after the strobe is first sampled. fifo_count goes 0→1→0.
- Fill and drain, DEPTH=4, smp_ready=0:
  - Stimulus: strobe 0x01..0x04.
  - Required: fifo_count=4, pad_busy=1.
  - Then raise smp_ready: smp_data reads 0x01,0x02,0x03,0x04 on consecutive cycles; pad_busy=0 after the first pop.
- Overflow:
  - Stimulus: with the FIFO full and smp_ready=0, strobe 0x55.
  - Required: pad_overflow=1 and stays 1; the FIFO still holds 0x01..0x04; 0x55 never appears.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full; smp_ready=1 on the exact cycle cap is high.
  - Required: fifo_count stays 4; pad_overflow=0; the new sample appears after the existing 3.
- Wrap-around:
  - Stimulus: 10 samples 0x10..0x19 with random smp_ready.
  - Required: outputs are in order 0x10..0x19 with no loss or duplication.
- Reset mid-operation:
  - Stimulus: 3 samples queued and pad_overflow set; assert wb_rst_i for 1 cycle while pad_strobe=1.
  - Required: all outputs 0 after the reset edge, then exactly one capture 3 cycles after release.

Source files
------------

// File: rtl/fuzzy_sample_loader_if.sv
// Sample stream from the pad loader to the fuzzy wavelet core.
// master drives data/valid, slave returns ready.
interface fuzzy_sample_loader_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic [DATA_W-1:0] smp_data;
   logic              smp_valid;
   logic              smp_ready;

   modport master (
      output smp_data,
      output smp_valid,
      input  smp_ready
   );

   modport slave (
      input  smp_data,
      input  smp_valid,
      output smp_ready
   );
endinterface

// File: rtl/fuzzy_sample_loader.sv
// Pad sample loader: synchronizes an async strobe/data pair and queues one sample per
// strobe rising edge in a first-word-fall-through FIFO drained over valid/ready.
module fuzzy_sample_loader #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic [DATA_W-1:0]     pad_data,
   input  logic                  pad_strobe,
   output logic                  pad_busy,
   output logic                  pad_overflow,
   output logic [CNT_W-1:0]      fifo_count,
   fuzzy_sample_loader_if.master smp
);
   localparam int unsigned      PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

   logic              s1_q, s2_q, s3_q;
   logic [DATA_W-1:0] d1_q, d2_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              busy_q;
   logic              overflow_q, overflow_d;
   logic              cap, full, push, pop, not_empty;

   // d1/d2 track s1/s2 so the captured data is aligned with the detected edge.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
         d1_q <= '0;
         d2_q <= '0;
      end else begin
         s1_q <= pad_strobe;
         s2_q <= s1_q;
         s3_q <= s2_q;
         d1_q <= pad_data;
         d2_q <= d1_q;
      end
   end

   always_comb begin
      not_empty  = (count_q != '0);
      full       = (count_q == FULL);
      cap        = s2_q & ~s3_q;
      pop        = not_empty & smp.smp_ready;
      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      push       = cap & (~full | pop);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (cap & full & ~pop);
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         busy_q     <= (count_d == FULL);
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= d2_q;
      end
   end

   assign smp.smp_valid = not_empty;
   assign smp.smp_data  = mem_q[rd_ptr_q];
   assign pad_busy      = busy_q;
   assign pad_overflow  = overflow_q;
   assign fifo_count    = count_q;
endmodule

// File: tb/tb_fuzzy_sample_loader.sv
// Self-checking bench for fuzzy_sample_loader: vector table for single-sample timing,
// scoreboard queue for FIFO ordering, hand-written sequences for full/overflow/reset cases.
module tb_fuzzy_sample_loader;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

   logic              clk;
   logic              rst;
   logic [DATA_W-1:0] pad_data;
   logic              pad_strobe;
   logic              pad_busy;
   logic              pad_overflow;
   logic [CNT_W-1:0]  fifo_count;

   fuzzy_sample_loader_if #(.DATA_W(DATA_W)) smp_bus ();

   fuzzy_sample_loader #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .pad_data    (pad_data),
      .pad_strobe  (pad_strobe),
      .pad_busy    (pad_busy),
      .pad_overflow(pad_overflow),
      .fifo_count  (fifo_count),
      .smp         (smp_bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  data;
      int unsigned hold;
      logic [7:0]  exp_valid;  // bit k-1: smp_valid expected k edges after strobe set
   } vec_t;

   vec_t       vecs[4];
   logic [7:0] sb[$];
   int         total = 0;
   int         bad = 0;
   bit         rand_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Called at a negedge: settle this cycle's ready, score any pop, advance one clock.
   task automatic step();
      logic [7:0] exp;
      if (rand_ready) smp_bus.smp_ready = 1'($urandom_range(0, 1));
      if (smp_bus.smp_valid === 1'b1 && smp_bus.smp_ready === 1'b1) begin
         if (sb.size() == 0) begin
            check("pop_unexpected", 32'(smp_bus.smp_data), 32'hFFFF_FFFF);
         end else begin
            exp = sb.pop_front();
            check("pop_data", 32'(smp_bus.smp_data), 32'(exp));
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] data, input bit keep);
      pad_data = data;
      repeat (3) step();
      pad_strobe = 1'b1;
      if (keep) sb.push_back(data);
      repeat (2) step();
      pad_strobe = 1'b0;
      repeat (2) step();
   endtask

   task automatic drain(input int n);
      smp_bus.smp_ready = 1'b1;
      repeat (n) step();
      smp_bus.smp_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{data: 8'hA5, hold: 4, exp_valid: 8'b0000_0100};
      vecs[1] = '{data: 8'h3C, hold: 2, exp_valid: 8'b0000_0100};
      vecs[2] = '{data: 8'hFF, hold: 6, exp_valid: 8'b0000_0100};
      vecs[3] = '{data: 8'h00, hold: 3, exp_valid: 8'b0000_0100};

      rst = 1'b1;
      pad_data = '0;
      pad_strobe = 1'b0;
      smp_bus.smp_ready = 1'b0;
      @(negedge clk);
      step();
      step();
      check("rst_valid", 32'(smp_bus.smp_valid), 32'd0);
      check("rst_busy", 32'(pad_busy), 32'd0);
      check("rst_ovf", 32'(pad_overflow), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      rst = 1'b0;
      step();

      // Single samples with ready high: 3-edge latency, one-cycle valid, no recapture.
      smp_bus.smp_ready = 1'b1;
      foreach (vecs[v]) begin
         pad_data = vecs[v].data;
         repeat (3) step();
         pad_strobe = 1'b1;
         sb.push_back(vecs[v].data);
         for (int k = 1; k <= 8; k++) begin
            step();
            if (k == int'(vecs[v].hold)) pad_strobe = 1'b0;
            check($sformatf("vec%0d_valid_k%0d", v, k), 32'(smp_bus.smp_valid),
                  32'(vecs[v].exp_valid[k-1]));
            check($sformatf("vec%0d_count_k%0d", v, k), 32'(fifo_count),
                  32'(vecs[v].exp_valid[k-1]));
         end
      end
      smp_bus.smp_ready = 1'b0;

      // Fill and drain.
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
      check("fill_count", 32'(fifo_count), 32'd4);
      check("fill_busy", 32'(pad_busy), 32'd1);
      drain(1);
      check("drain1_busy", 32'(pad_busy), 32'd0);
      check("drain1_count", 32'(fifo_count), 32'd3);
      drain(3);
      check("drain_empty", 32'(smp_bus.smp_valid), 32'd0);

      // Overflow: 0x55 is dropped, flag sticks.
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
      send(8'h55, 1'b0);
      check("ovf_set", 32'(pad_overflow), 32'd1);
      check("ovf_count", 32'(fifo_count), 32'd4);
      drain(4);
      check("ovf_sticky", 32'(pad_overflow), 32'd1);
      check("ovf_empty", 32'(smp_bus.smp_valid), 32'd0);

      // Full with pop on the exact capture cycle.
      do_reset();
      check("rst2_ovf", 32'(pad_overflow), 32'd0);
      for (int i = 1; i <= 4; i++) send(8'hA0 + 8'(i), 1'b1);
      pad_data = 8'h77;
      repeat (3) step();
      pad_strobe = 1'b1;
      sb.push_back(8'h77);
      step();
      step();
      smp_bus.smp_ready = 1'b1;
      step();
      smp_bus.smp_ready = 1'b0;
      check("pp_count", 32'(fifo_count), 32'd4);
      check("pp_ovf", 32'(pad_overflow), 32'd0);
      pad_strobe = 1'b0;
      repeat (2) step();
      drain(4);
      check("pp_empty", 32'(smp_bus.smp_valid), 32'd0);

      // Wrap-around with random ready.
      rand_ready = 1'b1;
      for (int i = 0; i < 10; i++) send(8'h10 + 8'(i), 1'b1);
      rand_ready = 1'b0;
      smp_bus.smp_ready = 1'b1;
      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      smp_bus.smp_ready = 1'b0;
      check("wrap_sb_left", 32'(sb.size()), 32'd0);
      check("wrap_ovf", 32'(pad_overflow), 32'd0);
      check("wrap_empty", 32'(smp_bus.smp_valid), 32'd0);

      // Reset mid-operation with strobe held high across release.
      for (int i = 1; i <= 4; i++) send(8'hB0 + 8'(i), 1'b1);
      send(8'h66, 1'b0);
      drain(1);
      check("mid_count", 32'(fifo_count), 32'd3);
      check("mid_ovf", 32'(pad_overflow), 32'd1);
      pad_data = 8'hC3;
      repeat (3) step();
      pad_strobe = 1'b1;
      step();
      do_reset();
      check("mrst_valid", 32'(smp_bus.smp_valid), 32'd0);
      check("mrst_busy", 32'(pad_busy), 32'd0);
      check("mrst_ovf", 32'(pad_overflow), 32'd0);
      check("mrst_count", 32'(fifo_count), 32'd0);
      sb.push_back(8'hC3);
      step();
      check("rel_e0_valid", 32'(smp_bus.smp_valid), 32'd0);
      step();
      check("rel_e1_valid", 32'(smp_bus.smp_valid), 32'd0);
      step();
      check("rel_e2_valid", 32'(smp_bus.smp_valid), 32'd1);
      check("rel_e2_data", 32'(smp_bus.smp_data), 32'hC3);
      repeat (3) step();
      check("rel_held_count", 32'(fifo_count), 32'd1);
      pad_strobe = 1'b0;
      drain(1);
      check("rel_empty", 32'(smp_bus.smp_valid), 32'd0);
      check("final_sb_left", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
